// File: rtl/sat_add_arb_pkg.sv
// Shared types and constants for the two-requester saturating adder block.
package sat_add_arb_pkg;

    // Width of the requester tag carried through the pipeline.
    localparam int REQ_ID_W = 1;

    // Saturation limits of a signed 16-bit result.
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    // One completed add as held in the response register.
    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        logic [15:0]         sum;
        logic                ovfl;
    } rsp_t;

endpackage

// File: rtl/sat_add_arb_if.sv
// Request/response bundle between the two requesters, the consumer and the adder block.
interface sat_add_arb_if;
    import sat_add_arb_pkg::*;

    logic                req0_valid;
    logic [15:0]         req0_a;
    logic [15:0]         req0_b;
    logic                req0_ready;
    logic                req1_valid;
    logic [15:0]         req1_a;
    logic [15:0]         req1_b;
    logic                req1_ready;
    logic                rsp_valid;
    logic [REQ_ID_W-1:0] rsp_id;
    logic [15:0]         rsp_sum;
    logic                rsp_ovfl;
    logic                rsp_ready;

    // Requester/consumer side.
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_ovfl
    );

    // Adder block side.
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_ovfl
    );

endinterface

// File: rtl/CLA_add_16.sv
// Library 16-bit carry-lookahead adder with signed saturation on overflow.
module CLA_add_16
    import sat_add_arb_pkg::*;
(
    output logic [15:0] Sum,
    output logic        Ovfl,
    input  logic [15:0] A,
    input  logic [15:0] B
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [15:0] carry;
    logic [15:0] raw;
    logic [2:0]  grp_g;
    logic [2:0]  grp_p;

    // Group generate/propagate give the carries at nibble boundaries, then clamp on signed overflow.
    always_comb begin
        gen   = A & B;
        prop  = A ^ B;
        grp_g = '0;
        grp_p = '0;
        carry = '0;
        for (int k = 0; k < 3; k++) begin
            grp_p[k] = &prop[4*k +: 4];
            grp_g[k] = gen[4*k+3]
                     | (prop[4*k+3] & gen[4*k+2])
                     | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                     | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
        end
        for (int i = 0; i < 15; i++) begin
            if (i % 4 == 3) begin
                carry[i+1] = grp_g[i/4] | (grp_p[i/4] & carry[i-3]);
            end else begin
                carry[i+1] = gen[i] | (prop[i] & carry[i]);
            end
        end
        raw  = prop ^ carry;
        Ovfl = (A[15] == B[15]) && (raw[15] != A[15]);
        if (Ovfl) begin
            Sum = A[15] ? SAT_NEG : SAT_POS;
        end else begin
            Sum = raw;
        end
    end

endmodule

// File: rtl/sat_add_arb_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    assign grant0 = enable & valid0 & (~valid1 | last_grant);
    assign grant1 = enable & valid1 & (~valid0 | ~last_grant);

    // Remember the most recent winner; reset points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/sat_add_arb.sv
// Shares one saturating adder between two requesters through an operand stage and a response stage.
module sat_add_arb
    import sat_add_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sat_add_arb_if.slave     bus,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    logic                op_valid;
    logic [REQ_ID_W-1:0] op_id;
    logic [15:0]         op_a;
    logic [15:0]         op_b;
    logic                rsp_valid;
    rsp_t                rsp_q;
    logic                rsp_take;
    logic                s2_free;
    logic                s1_adv;
    logic                s1_free;
    logic                grant0;
    logic                grant1;
    logic [15:0]         add_sum;
    logic                add_ovfl;

    assign rsp_take = rsp_valid & bus.rsp_ready;
    assign s2_free  = ~rsp_valid | rsp_take;
    assign s1_adv   = op_valid & s2_free;
    assign s1_free  = ~op_valid | s1_adv;

    // Grants are only offered when the operand stage can take a new operation.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .enable (s1_free),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign bus.req0_ready = s1_free & grant0;
    assign bus.req1_ready = s1_free & grant1;

    CLA_add_16 u_add (
        .Sum  (add_sum),
        .Ovfl (add_ovfl),
        .A    (op_a),
        .B    (op_b)
    );

    // Operand stage: capture the granted request, or empty out when the held op moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_id    <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (s1_free) begin
            op_valid <= grant0 | grant1;
            if (grant1) begin
                op_id <= REQ_ID_W'(1);
                op_a  <= bus.req1_a;
                op_b  <= bus.req1_b;
            end else if (grant0) begin
                op_id <= '0;
                op_a  <= bus.req0_a;
                op_b  <= bus.req0_b;
            end
        end
    end

    // Response stage: load the adder result whenever the current response is gone or being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (s2_free) begin
            rsp_valid <= s1_adv;
            if (s1_adv) begin
                rsp_q.id   <= op_id;
                rsp_q.sum  <= add_sum;
                rsp_q.ovfl <= add_ovfl;
            end
        end
    end

    // Count delivered overflow responses, sticking at all-ones; clear wins over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (rsp_take && rsp_q.ovfl && !(&sat_cnt)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_q.id;
    assign bus.rsp_sum   = rsp_q.sum;
    assign bus.rsp_ovfl  = rsp_q.ovfl;

endmodule

// File: tb/tb_sat_add_arb.sv
// Self-checking bench: vector table, hand-written pipeline corner cases and a randomized run against a queue model.
module tb_sat_add_arb;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             sat_clr;
    logic [CNT_W-1:0] sat_cnt;
    int               errors;
    int               checks;

    sat_add_arb_if bus ();

    sat_add_arb #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sat_cnt (sat_cnt),
        .sat_clr (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_sum;
        logic        exp_ovfl;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        bit          aged;
    } ent_t;

    vec_t        vecs[12];
    ent_t        q[$];
    ent_t        e;
    logic        mdl_last;
    int          mdl_cnt;
    int          exp_cnt;
    logic        pend0, pend1;
    logic [15:0] a0, b0, a1, b1;
    logic        exp_rv, take, room, win0, win1;
    logic [15:0] es;
    logic        eo;

    // Compare one observed value against the bench's expectation and tally the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = 16'($urandom);
        bus.req0_b     = 16'($urandom);
        bus.req1_a     = 16'($urandom);
        bus.req1_b     = 16'($urandom);
        bus.rsp_ready  = 1'b0;
        sat_clr        = 1'b0;
    endtask

    task automatic expectRsp(input string tag, input logic v, input logic id, input logic [15:0] sum, input logic ovfl);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, v);
        if (v) begin
            checkOutput({tag, "_rsp_id"}, bus.rsp_id, id);
            checkOutput({tag, "_rsp_sum"}, bus.rsp_sum, sum);
            checkOutput({tag, "_rsp_ovfl"}, bus.rsp_ovfl, ovfl);
        end
    endtask

    task automatic expectReady(input string tag, input logic r0, input logic r1);
        checkOutput({tag, "_ready0"}, bus.req0_ready, r0);
        checkOutput({tag, "_ready1"}, bus.req1_ready, r1);
    endtask

    // Hold reset across two edges with quiet inputs, check the cleared state, then release.
    task automatic doReset();
        idleInputs();
        rst_n = 1'b0;
        tick();
        tick();
        expectRsp("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset_rsp_id", bus.rsp_id, 0);
        checkOutput("reset_rsp_sum", bus.rsp_sum, 0);
        checkOutput("reset_rsp_ovfl", bus.rsp_ovfl, 0);
        checkOutput("reset_sat_cnt", sat_cnt, 0);
        expectReady("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
    endtask

    // Present one request, wait (bounded) for its ready, let the edge accept it, then withdraw.
    task automatic applyStimulus(input logic id, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end
        #1;
        while (((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) && n < 8) begin
            tick();
            n++;
        end
        checkOutput("accept_ready", id ? bus.req1_ready : bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Signed 16-bit add clamped to the representable range, done with plain integer arithmetic.
    function automatic void ref_add(input logic [15:0] a, input logic [15:0] b, output logic [15:0] s, output logic o);
        int t;
        t = int'($signed(a)) + int'($signed(b));
        if (t > 32767) begin
            s = 16'h7FFF;
            o = 1'b1;
        end else if (t < -32768) begin
            s = 16'h8000;
            o = 1'b1;
        end else begin
            s = t[15:0];
            o = 1'b0;
        end
    endfunction

    // Operands biased toward the extremes so saturation shows up often.
    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 16'h6000 + 16'($urandom_range(0, 16'h3FFF));
            1:       return 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
            2:       return 16'($urandom);
            default: return 16'($urandom_range(0, 255));
        endcase
    endfunction

    // Global bound so a stuck design still ends with a failure line.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;

        vecs = '{
            '{1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0},
            '{1'b1, 16'h7000, 16'h2000, 16'h7FFF, 1'b1},
            '{1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1},
            '{1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1},
            '{1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b1},
            '{1'b1, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b0},
            '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0},
            '{1'b1, 16'h4000, 16'h4000, 16'h7FFF, 1'b1},
            '{1'b0, 16'hC000, 16'hC000, 16'h8000, 1'b0},
            '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0},
            '{1'b0, 16'h7FFE, 16'h0001, 16'h7FFF, 1'b0},
            '{1'b1, 16'h8001, 16'hFFFF, 16'h8000, 1'b0}
        };

        // Vector table: one isolated transaction each, checking 2-edge latency and the counter.
        doReset();
        bus.rsp_ready = 1'b1;
        exp_cnt = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b);
            checkOutput("tbl_early_valid", bus.rsp_valid, 0);
            tick();
            expectRsp("tbl", 1'b1, vecs[i].id, vecs[i].exp_sum, vecs[i].exp_ovfl);
            tick();
            if (vecs[i].exp_ovfl) exp_cnt++;
            checkOutput("tbl_sat_cnt", sat_cnt, exp_cnt);
        end

        // Round-robin: both requesters busy for four cycles, accepted 0,1,0,1 back to back.
        doReset();
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0010; bus.req0_b = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h0100; bus.req1_b = 16'h0002;
        #1;
        expectReady("rr_c0", 1'b1, 1'b0);
        expectRsp("rr_c0", 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        bus.req0_a = 16'h0020;
        #1;
        expectReady("rr_c1", 1'b0, 1'b1);
        expectRsp("rr_c1", 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        bus.req1_a = 16'h0200;
        #1;
        expectReady("rr_c2", 1'b1, 1'b0);
        expectRsp("rr_c2", 1'b1, 1'b0, 16'h0011, 1'b0);
        tick();
        expectReady("rr_c3", 1'b0, 1'b1);
        expectRsp("rr_c3", 1'b1, 1'b1, 16'h0102, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        expectRsp("rr_c4", 1'b1, 1'b0, 16'h0021, 1'b0);
        tick();
        expectRsp("rr_c5", 1'b1, 1'b1, 16'h0202, 1'b0);
        tick();
        expectRsp("rr_c6", 1'b0, 1'b0, 16'h0000, 1'b0);

        // Backpressure: consumer stalls, exactly two ops get in, then the drain has no bubble.
        doReset();
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h0005; bus.req1_b = 16'h0005;
        #1;
        expectReady("bp_c0", 1'b1, 1'b0);
        tick();
        bus.req0_a = 16'h0003; bus.req0_b = 16'h0003;
        #1;
        expectReady("bp_c1", 1'b0, 1'b1);
        expectRsp("bp_c1", 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            expectReady("bp_hold", 1'b0, 1'b0);
            expectRsp("bp_hold", 1'b1, 1'b0, 16'h0002, 1'b0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        expectReady("bp_release", 1'b1, 1'b0);
        expectRsp("bp_release", 1'b1, 1'b0, 16'h0002, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        expectRsp("bp_drain1", 1'b1, 1'b1, 16'h000A, 1'b0);
        tick();
        expectRsp("bp_drain2", 1'b1, 1'b0, 16'h0006, 1'b0);
        tick();
        expectRsp("bp_empty", 1'b0, 1'b0, 16'h0000, 1'b0);

        // Counter limit: a long stream of positive overflows must stick at all-ones.
        doReset();
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h7000; bus.req0_b = 16'h2000;
        for (int i = 1; i <= 310; i++) begin
            tick();
            if (i == 100 || i == 256 || i == 257 || i == 258 || i == 310)
                checkOutput("stream_sat_cnt", sat_cnt, ((i - 2) > CNT_MAX) ? CNT_MAX : (i - 2));
        end

        // Clear in the same cycle as an overflow take wins, and the following take counts from zero.
        sat_clr        = 1'b1;
        bus.req0_valid = 1'b0;
        #1;
        expectRsp("clr_pre", 1'b1, 1'b0, 16'h7FFF, 1'b1);
        tick();
        sat_clr = 1'b0;
        checkOutput("clr_sat_cnt", sat_cnt, 0);
        checkOutput("clr_rsp_valid", bus.rsp_valid, 1);
        tick();
        checkOutput("clr_next_sat_cnt", sat_cnt, 1);
        checkOutput("clr_empty", bus.rsp_valid, 0);

        // Reset with both stages full drops everything and re-arms the tie-break toward requester 0.
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0011; bus.req0_b = 16'h0011;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h0022; bus.req1_b = 16'h0022;
        tick();
        tick();
        expectReady("mid_full", 1'b0, 1'b0);
        expectRsp("mid_full", 1'b1, 1'b1, 16'h0044, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("mid_rst_sat_cnt", sat_cnt, 0);
        tick();
        checkOutput("mid_rst_hold_valid", bus.rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        expectReady("post_rst", 1'b1, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        checkOutput("post_rst_no_stale", bus.rsp_valid, 0);
        tick();
        expectRsp("post_rst", 1'b1, 1'b0, 16'h0022, 1'b0);
        tick();
        checkOutput("post_rst_empty", bus.rsp_valid, 0);

        // Randomized run: the model is a two-entry FIFO of accepted ops plus an integer counter.
        doReset();
        q.delete();
        mdl_last = 1'b1;
        mdl_cnt  = 0;
        pend0    = 1'b0;
        pend1    = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend0 && $urandom_range(0, 99) < 60) begin
                pend0 = 1'b1; a0 = rand_op(); b0 = rand_op();
            end
            if (!pend1 && $urandom_range(0, 99) < 60) begin
                pend1 = 1'b1; a1 = rand_op(); b1 = rand_op();
            end
            bus.req0_valid = pend0;
            bus.req0_a     = pend0 ? a0 : 16'($urandom);
            bus.req0_b     = pend0 ? b0 : 16'($urandom);
            bus.req1_valid = pend1;
            bus.req1_a     = pend1 ? a1 : 16'($urandom);
            bus.req1_b     = pend1 ? b1 : 16'($urandom);
            bus.rsp_ready  = ($urandom_range(0, 99) < 70);
            sat_clr        = ($urandom_range(0, 99) < 3);
            #1;
            exp_rv = (q.size() > 0) && q[0].aged;
            take   = exp_rv && bus.rsp_ready;
            room   = (q.size() - (take ? 1 : 0)) < 2;
            win0   = room && pend0 && (!pend1 || mdl_last);
            win1   = room && pend1 && (!pend0 || !mdl_last);
            eo     = 1'b0;
            es     = '0;
            expectReady("rnd", win0, win1);
            checkOutput("rnd_rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv) begin
                ref_add(q[0].a, q[0].b, es, eo);
                checkOutput("rnd_rsp_id", bus.rsp_id, q[0].id);
                checkOutput("rnd_rsp_sum", bus.rsp_sum, es);
                checkOutput("rnd_rsp_ovfl", bus.rsp_ovfl, eo);
            end
            checkOutput("rnd_sat_cnt", sat_cnt, mdl_cnt);
            tick();
            if (sat_clr) mdl_cnt = 0;
            else if (take && eo && mdl_cnt < CNT_MAX) mdl_cnt++;
            if (take) void'(q.pop_front());
            foreach (q[j]) q[j].aged = 1'b1;
            if (win0) begin
                e.id = 1'b0; e.a = a0; e.b = b0; e.aged = 1'b0;
                q.push_back(e);
                pend0    = 1'b0;
                mdl_last = 1'b0;
            end
            if (win1) begin
                e.id = 1'b1; e.a = a1; e.b = b1; e.aged = 1'b0;
                q.push_back(e);
                pend1    = 1'b0;
                mdl_last = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sat_add_arb.md
Name: sat_add_arb

Overview:
- Shares one 16-bit saturating adder (CLA_add_16: Sum, Ovfl, A, B) between two requesters, e.g. ALU-side and address-calc-side.
- Provides a round-robin arbiter, a 2-stage pipeline (operand register, then result register) and one shared response channel tagged with the requester ID.
- Counts saturation events for debug/perf.

Parameters:
- CNT_W, 8, width of the saturation-event counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_a  in  16  requester 0 operand A (signed)
- req0_b  in  16  requester 0 operand B (signed)
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  response register holds a result
- rsp_id  out  1  requester that owns the response
- rsp_sum  out  16  saturated sum
- rsp_ovfl  out  1  signed overflow flag of that add
- rsp_ready  in  1  consumer takes the response
- sat_cnt  out  CNT_W  number of responses delivered with rsp_ovfl=1
- sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset (async assert, sync-safe deassert):
  - op_valid=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ovfl=0, sat_cnt=0, last_grant=1.
  - req0_ready and req1_ready go combinationally to 0 because the pipeline is empty and nothing is granted.
- Stage definitions:
  - S1 is the operand register: op_a, op_b, op_id, op_valid.
  - S2 is the response register: rsp_*.
  - The adder is purely combinational from op_a/op_b.
- Advance conditions:
  - rsp_take = rsp_valid & rsp_ready.
  - s2_free = ~rsp_valid | rsp_take.
  - s1_adv = op_valid & s2_free.
  - s1_free = ~op_valid | s1_adv.
- Arbitration (combinational, evaluated only when s1_free=1):
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - After reset, requester 0 wins the first tie.
  - reqX_ready = s1_free & grantX. At most one ready is high per cycle.
  - last_grant updates only on an accepted request (valid & ready).
- Handshake: a request is accepted when reqX_valid & reqX_ready at a clock edge.
  - The requester must hold valid/operands stable until accepted.
  - The block never drops an accepted operation.
- Latency:
  - Accept at edge T puts the operation in S1.
  - With S2 free, edge T+1 loads rsp_sum, rsp_ovfl and rsp_id. rsp_valid is high from T+1 until the edge where rsp_take is true.
  - Minimum latency is 2 edges. Throughput is 1 operation per cycle with rsp_ready tied high.
- Backpressure:
  - rsp_ready=0 with rsp_valid=1: S2 holds, S1 holds if occupied, and both readys drop once S1 is full.
  - On the same-cycle take, S2 reloads from S1 and S1 may accept a new request (full-throughput drain, no bubble).
- Arithmetic:
  - rsp_sum and rsp_ovfl come from the adder unchanged.
  - If Ovfl=1 and both signs are 1: rsp_sum = 16'h8000.
  - If Ovfl=1 and both signs are 0: rsp_sum = 16'h7FFF.
  - Otherwise rsp_sum = A+B mod 2^16.
- sat_cnt:
  - Increments on rsp_take & rsp_ovfl, and saturates at all-ones (no wrap).
  - sat_clr has priority over an increment in the same cycle; the result is 0.
- Reset mid-operation: all in-flight S1/S2 contents are discarded with no response emitted, and last_grant returns to 1.
- Requests with invalid operands are not possible; X on operands when valid=0 must not propagate to outputs.

Decomposition:
- Shared package: REQ_ID_W=1, SAT_POS=16'h7FFF, SAT_NEG=16'h8000, the response-record typedef (id, sum, ovfl).
- One sub-module: rr_arb2, a 2-input round-robin arbiter holding last_grant (inputs valid0/valid1/enable, outputs grant0/grant1).
- The adder is an instance of CLA_add_16. Do not reimplement it.

Test Plan:
- Single add, rsp_ready=1: req0 a=16'h0003 b=16'h0004 accepted at T -> at T+1 rsp_valid=1, rsp_id=0, rsp_sum=16'h0007, rsp_ovfl=0.
- Positive saturation: req1 a=16'h7000 b=16'h2000 -> rsp_sum=16'h7FFF, rsp_ovfl=1, sat_cnt 0->1 on take. Negative saturation: a=16'h8000 b=16'hFFFF -> rsp_sum=16'h8000, rsp_ovfl=1.
- Round-robin: both valid continuously for 4 cycles after reset, rsp_ready=1 -> acceptance order 0,1,0,1, responses in the same order with matching rsp_id, one response per cycle.
- Backpressure: rsp_ready=0 while 3 requests are pending -> exactly 2 accepted (S1+S2 full), both readys low, rsp_* stable. Release rsp_ready -> responses drain in order, one per cycle, with no loss or duplication.
- Counter limits: force 300 overflow responses -> sat_cnt holds 8'hFF. Assert sat_clr in the same cycle as an overflow take -> sat_cnt=0.
- Reset mid-flight: assert rst_n=0 with S1 and S2 full -> immediately rsp_valid=0, sat_cnt=0. After release, with both requesters valid, the first grant goes to requester 0.
